// File: rtl/paquete_bcd_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// paquete_bcd_pkg: shared types and constants for the BCD arbiter
// Rev 1.0
// ------------------------------------------------------------------
package paquete_bcd_pkg;

  typedef enum logic [2:0] {
    REPOSO   = 3'd0,
    LANZAR   = 3'd1,
    ASENTAR  = 3'd2,
    ESPERAR  = 3'd3,
    ENTREGAR = 3'd4
  } estado_t;

  localparam int unsigned MAX_DECIMAL     = 9999;
  localparam logic [15:0] DIGITOS_RANGO   = 16'hEEEE;
  localparam logic [15:0] DIGITOS_TIMEOUT = 16'hFFFF;

endpackage
`default_nettype wire

// File: rtl/module_arbitro_rr.sv
`default_nettype none
// ------------------------------------------------------------------
// module_arbitro_rr: two-way round-robin arbiter with one-hot grant
// Rev 1.0
// ------------------------------------------------------------------
module module_arbitro_rr (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sol,
  input  logic       avanzar,
  output logic [1:0] conc
);

  // Set when requester B was the last one granted; reset favours A.
  logic r_ultimo_b;

  always_comb begin
    conc = sol;
    if (sol == 2'b11) begin
      conc = r_ultimo_b ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ultimo_b <= 1'b1;
    end else if (avanzar) begin
      r_ultimo_b <= conc[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/module_bcd_arbitro.sv
`default_nettype none
// ------------------------------------------------------------------
// module_bcd_arbitro: shares one binary-to-BCD converter between two requesters
// Rev 1.0
// ------------------------------------------------------------------
module module_bcd_arbitro
  import paquete_bcd_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = 64,
  parameter int ANCHO          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sol_valido_a,
  input  logic             sol_valido_b,
  input  logic [ANCHO-1:0] sol_numero_a,
  input  logic [ANCHO-1:0] sol_numero_b,
  output logic             sol_acepta_a,
  output logic             sol_acepta_b,
  output logic             res_valido_a,
  output logic             res_valido_b,
  output logic [15:0]      res_digitos_a,
  output logic [15:0]      res_digitos_b,
  output logic [ANCHO-1:0] bcd_numero,
  input  logic [3:0]       bcd_unidades,
  input  logic [3:0]       bcd_decenas,
  input  logic [3:0]       bcd_centenas,
  input  logic [3:0]       bcd_millares,
  input  logic             bcd_listo,
  output logic             error_timeout,
  output logic             fuera_rango
);

  localparam int CW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam int AW = (ANCHO > 14) ? ANCHO : 14;
  localparam logic [CW-1:0] C_ULTIMA = CW'(TIMEOUT_CICLOS - 1);
  localparam logic [AW-1:0] C_MAX    = AW'(MAX_DECIMAL);

  estado_t          r_estado;
  estado_t          w_estado_sig;
  logic             r_dueno_b;
  logic             r_rango;
  logic [CW-1:0]    r_cuenta;
  logic [1:0]       w_sol;
  logic [1:0]       w_conc;
  logic             w_avanzar;
  logic [ANCHO-1:0] w_numero;
  logic             w_fuera;
  logic             w_fin;
  logic             w_cargar;
  logic             w_dest_b;
  logic [15:0]      w_digitos;

  assign w_sol     = {sol_valido_b, sol_valido_a};
  assign w_avanzar = (r_estado == REPOSO) && (w_sol != 2'b00);

  module_arbitro_rr u_arbitro (
    .clk     (clk),
    .rst     (rst),
    .sol     (w_sol),
    .avanzar (w_avanzar),
    .conc    (w_conc)
  );

  assign w_numero = w_conc[1] ? sol_numero_b : sol_numero_a;
  assign w_fuera  = AW'(w_numero) > C_MAX;
  assign w_fin    = (r_cuenta == C_ULTIMA);

  // Result digits are written on the edge entering ENTREGAR so they are
  // already stable while res_valido is high.
  always_comb begin
    w_estado_sig = r_estado;
    w_cargar     = 1'b0;
    w_dest_b     = r_dueno_b;
    w_digitos    = DIGITOS_TIMEOUT;
    case (r_estado)
      REPOSO: begin
        if (w_avanzar) begin
          if (w_fuera) begin
            w_estado_sig = ENTREGAR;
            w_cargar     = 1'b1;
            w_dest_b     = w_conc[1];
            w_digitos    = DIGITOS_RANGO;
          end else begin
            w_estado_sig = LANZAR;
          end
        end
      end
      LANZAR:  w_estado_sig = ASENTAR;
      ASENTAR: w_estado_sig = ESPERAR;
      ESPERAR: begin
        if (bcd_listo) begin
          w_estado_sig = ENTREGAR;
          w_cargar     = 1'b1;
          w_digitos    = {bcd_millares, bcd_centenas, bcd_decenas, bcd_unidades};
        end else if (w_fin) begin
          w_estado_sig = ENTREGAR;
          w_cargar     = 1'b1;
          w_digitos    = DIGITOS_TIMEOUT;
        end
      end
      ENTREGAR: w_estado_sig = REPOSO;
      default:  w_estado_sig = REPOSO;
    endcase
  end

  assign sol_acepta_a = (r_estado == REPOSO) && w_conc[0];
  assign sol_acepta_b = (r_estado == REPOSO) && w_conc[1];
  assign res_valido_a = (r_estado == ENTREGAR) && !r_dueno_b;
  assign res_valido_b = (r_estado == ENTREGAR) && r_dueno_b;
  assign fuera_rango  = (r_estado == ENTREGAR) && r_rango;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_estado <= REPOSO;
    end else begin
      r_estado <= w_estado_sig;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dueno_b     <= 1'b0;
      r_rango       <= 1'b0;
      r_cuenta      <= '0;
      bcd_numero    <= '0;
      error_timeout <= 1'b0;
      res_digitos_a <= '0;
      res_digitos_b <= '0;
    end else begin
      if (w_avanzar) begin
        r_dueno_b <= w_conc[1];
        r_rango   <= w_fuera;
        if (!w_fuera) begin
          bcd_numero <= w_numero;
        end
      end
      if (r_estado == ASENTAR) begin
        r_cuenta <= '0;
      end else if ((r_estado == ESPERAR) && !bcd_listo && !w_fin) begin
        r_cuenta <= r_cuenta + CW'(1);
      end
      if ((r_estado == ESPERAR) && !bcd_listo && w_fin) begin
        error_timeout <= 1'b1;
      end
      if (w_cargar) begin
        if (w_dest_b) begin
          res_digitos_b <= w_digitos;
        end else begin
          res_digitos_a <= w_digitos;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_module_bcd_arbitro.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_module_bcd_arbitro: directed vectors for the shared BCD arbiter
// Rev 1.0
// ------------------------------------------------------------------
module tb_module_bcd_arbitro;

  logic        clk;
  logic        rst;
  logic        sol_valido_a, sol_valido_b;
  logic [15:0] sol_numero_a, sol_numero_b;
  logic        sol_acepta_a, sol_acepta_b;
  logic        res_valido_a, res_valido_b;
  logic [15:0] res_digitos_a, res_digitos_b;
  logic [15:0] bcd_numero;
  logic [3:0]  bcd_unidades, bcd_decenas, bcd_centenas, bcd_millares;
  logic        bcd_listo;
  logic        error_timeout;
  logic        fuera_rango;

  int checks = 0;
  int failures = 0;

  // Converter model: digits of bcd_numero, listo a set delay after a grant.
  int cnt_conv = 1000;
  int retardo = 0;
  bit atascado = 1'b0;

  typedef struct {
    bit          es_b;
    logic [15:0] numero;
    int          retardo;
    bit          atascado;
    logic [15:0] exp_dig;
    int          exp_lat;
    bit          exp_fuera;
    logic [15:0] exp_bcd;
  } vec_t;

  vec_t        tabla[6];
  logic [15:0] lista_a[3];
  logic [15:0] lista_b[3];
  logic [15:0] hex_a[3];
  logic [15:0] hex_b[3];

  module_bcd_arbitro #(.TIMEOUT_CICLOS(8), .ANCHO(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .sol_valido_a  (sol_valido_a),
    .sol_valido_b  (sol_valido_b),
    .sol_numero_a  (sol_numero_a),
    .sol_numero_b  (sol_numero_b),
    .sol_acepta_a  (sol_acepta_a),
    .sol_acepta_b  (sol_acepta_b),
    .res_valido_a  (res_valido_a),
    .res_valido_b  (res_valido_b),
    .res_digitos_a (res_digitos_a),
    .res_digitos_b (res_digitos_b),
    .bcd_numero    (bcd_numero),
    .bcd_unidades  (bcd_unidades),
    .bcd_decenas   (bcd_decenas),
    .bcd_centenas  (bcd_centenas),
    .bcd_millares  (bcd_millares),
    .bcd_listo     (bcd_listo),
    .error_timeout (error_timeout),
    .fuera_rango   (fuera_rango)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] a_bcd(input logic [15:0] n);
    int v;
    v = int'(n) % 10000;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  assign {bcd_millares, bcd_centenas, bcd_decenas, bcd_unidades} = a_bcd(bcd_numero);
  assign bcd_listo = !atascado && (cnt_conv >= retardo);

  always @(posedge clk) begin
    if (sol_acepta_a || sol_acepta_b) cnt_conv <= 0;
    else if (cnt_conv < 1000) cnt_conv <= cnt_conv + 1;
  end

  task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nombre, act, exp);
    end
  endtask

  // One request from a single requester; starts and ends at a negedge in REPOSO.
  task automatic run_single(input vec_t v, input int id);
    int          lat;
    bit          ok;
    bit          otro_v;
    bit          fuera_v;
    logic [15:0] otro_prev;
    retardo   = v.retardo;
    atascado  = v.atascado;
    otro_prev = v.es_b ? res_digitos_a : res_digitos_b;
    if (v.es_b) begin sol_numero_b = v.numero; sol_valido_b = 1'b1; end
    else begin sol_numero_a = v.numero; sol_valido_a = 1'b1; end
    #1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (v.es_b ? sol_acepta_b : sol_acepta_a) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
    chk($sformatf("v%0d_acepta", id), 32'(ok), 32'd1);
    @(posedge clk); #1;
    sol_valido_a = 1'b0;
    sol_valido_b = 1'b0;
    chk($sformatf("v%0d_acepta_pulso", id), 32'(sol_acepta_a || sol_acepta_b), 32'd0);
    lat = 0; otro_v = 1'b0; fuera_v = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (v.es_b ? res_valido_a : res_valido_b) otro_v = 1'b1;
      if (v.es_b ? res_valido_b : res_valido_a) begin
        lat = k;
        fuera_v = fuera_rango;
        break;
      end
    end
    chk($sformatf("v%0d_latencia", id), 32'(lat), 32'(v.exp_lat));
    chk($sformatf("v%0d_digitos", id), 32'(v.es_b ? res_digitos_b : res_digitos_a), 32'(v.exp_dig));
    chk($sformatf("v%0d_fuera_rango", id), 32'(fuera_v), 32'(v.exp_fuera));
    chk($sformatf("v%0d_bcd_numero", id), 32'(bcd_numero), 32'(v.exp_bcd));
    chk($sformatf("v%0d_otro_valido", id), 32'(otro_v), 32'd0);
    chk($sformatf("v%0d_otro_digitos", id), 32'(v.es_b ? res_digitos_a : res_digitos_b), 32'(otro_prev));
    @(negedge clk);
    chk($sformatf("v%0d_valido_pulso", id), 32'(res_valido_a || res_valido_b), 32'd0);
  endtask

  initial begin
    bit   ok;
    bit   visto;
    bit   upd_a, upd_b;
    int   ia, ib, ra, rb, grants;
    vec_t v;

    rst = 1'b0;
    sol_valido_a = 1'b0; sol_valido_b = 1'b0;
    sol_numero_a = '0;   sol_numero_b = '0;

    tabla[0] = '{1'b0, 16'd1234,  5, 1'b0, 16'h1234, 7, 1'b0, 16'd1234};
    tabla[1] = '{1'b1, 16'd10000, 0, 1'b0, 16'hEEEE, 1, 1'b1, 16'd1234};
    tabla[2] = '{1'b0, 16'd9999,  0, 1'b0, 16'h9999, 4, 1'b0, 16'd9999};
    tabla[3] = '{1'b1, 16'd0,     3, 1'b0, 16'h0000, 5, 1'b0, 16'd0};
    tabla[4] = '{1'b0, 16'd65535, 0, 1'b0, 16'hEEEE, 1, 1'b1, 16'd0};
    tabla[5] = '{1'b1, 16'd7,     2, 1'b0, 16'h0007, 4, 1'b0, 16'd7};
    lista_a = '{16'd1111, 16'd2222, 16'd3333};
    lista_b = '{16'd4444, 16'd5555, 16'd6666};
    hex_a   = '{16'h1111, 16'h2222, 16'h3333};
    hex_b   = '{16'h4444, 16'h5555, 16'h6666};

    repeat (2) @(negedge clk);
    #1;
    chk("rst_acepta",    32'({sol_acepta_a, sol_acepta_b}), 32'd0);
    chk("rst_valido",    32'({res_valido_a, res_valido_b}), 32'd0);
    chk("rst_digitos_a", 32'(res_digitos_a), 32'd0);
    chk("rst_digitos_b", 32'(res_digitos_b), 32'd0);
    chk("rst_bcd",       32'(bcd_numero), 32'd0);
    chk("rst_error",     32'(error_timeout), 32'd0);
    chk("rst_fuera",     32'(fuera_rango), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Simultaneous first request: A wins, B follows.
    retardo = 0;
    sol_numero_a = 16'd5678; sol_numero_b = 16'd910;
    sol_valido_a = 1'b1;     sol_valido_b = 1'b1;
    #1;
    chk("sim_acepta_a", 32'(sol_acepta_a), 32'd1);
    chk("sim_acepta_b", 32'(sol_acepta_b), 32'd0);
    @(posedge clk); #1;
    sol_valido_a = 1'b0;
    visto = 1'b0; ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (sol_acepta_b) visto = 1'b1;
      if (res_valido_a) begin ok = 1'b1; break; end
    end
    chk("sim_res_a",        32'(ok), 32'd1);
    chk("sim_digitos_a",    32'(res_digitos_a), 32'h5678);
    chk("sim_b_no_acepta",  32'(visto), 32'd0);
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (sol_acepta_b) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
    chk("sim_acepta_b2", 32'(ok), 32'd1);
    @(posedge clk); #1;
    sol_valido_b = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (res_valido_b) begin ok = 1'b1; break; end
    end
    chk("sim_res_b",     32'(ok), 32'd1);
    chk("sim_digitos_b", 32'(res_digitos_b), 32'h0910);
    chk("sim_digitos_a2", 32'(res_digitos_a), 32'h5678);
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_single(tabla[i], i);

    // Converter never answers.
    chk("tmo_error_antes", 32'(error_timeout), 32'd0);
    v = '{1'b0, 16'd42, 0, 1'b1, 16'hFFFF, 11, 1'b0, 16'd42};
    run_single(v, 10);
    chk("tmo_error", 32'(error_timeout), 32'd1);
    v = '{1'b1, 16'd7, 0, 1'b0, 16'h0007, 4, 1'b0, 16'd7};
    run_single(v, 11);
    chk("tmo_error_pegado", 32'(error_timeout), 32'd1);

    // Reset while waiting on the converter.
    atascado = 1'b1;
    sol_numero_a = 16'd1234; sol_valido_a = 1'b1;
    #1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (sol_acepta_a) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
    chk("rstw_acepta", 32'(ok), 32'd1);
    @(posedge clk); #1;
    sol_valido_a = 1'b0;
    visto = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (res_valido_a) visto = 1'b1;
    end
    rst = 1'b0;
    #1;
    chk("rstw_acepta0",   32'({sol_acepta_a, sol_acepta_b}), 32'd0);
    chk("rstw_valido0",   32'({res_valido_a, res_valido_b}), 32'd0);
    chk("rstw_digitos_a", 32'(res_digitos_a), 32'd0);
    chk("rstw_digitos_b", 32'(res_digitos_b), 32'd0);
    chk("rstw_bcd",       32'(bcd_numero), 32'd0);
    chk("rstw_error",     32'(error_timeout), 32'd0);
    chk("rstw_fuera",     32'(fuera_rango), 32'd0);
    @(negedge clk);
    if (res_valido_a) visto = 1'b1;
    rst = 1'b1;
    chk("rstw_sin_res", 32'(visto), 32'd0);
    v = '{1'b0, 16'd9999, 0, 1'b0, 16'h9999, 4, 1'b0, 16'd9999};
    run_single(v, 12);

    // Both requesters held valid: grants alternate A,B,A,B,A,B.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    retardo = 0; atascado = 1'b0;
    sol_numero_a = lista_a[0]; sol_numero_b = lista_b[0];
    sol_valido_a = 1'b1;       sol_valido_b = 1'b1;
    ia = 0; ib = 0; ra = 0; rb = 0; grants = 0; upd_a = 1'b0; upd_b = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (upd_a) begin
        ia++;
        if (ia < 3) sol_numero_a = lista_a[ia]; else sol_valido_a = 1'b0;
        upd_a = 1'b0;
      end
      if (upd_b) begin
        ib++;
        if (ib < 3) sol_numero_b = lista_b[ib]; else sol_valido_b = 1'b0;
        upd_b = 1'b0;
      end
      #1;
      if (sol_acepta_a || sol_acepta_b) begin
        chk($sformatf("rr_grant%0d_es_b", grants), 32'(sol_acepta_b), 32'(grants % 2));
        chk($sformatf("rr_grant%0d_onehot", grants), 32'(sol_acepta_a && sol_acepta_b), 32'd0);
        if (sol_acepta_a) upd_a = 1'b1;
        if (sol_acepta_b) upd_b = 1'b1;
        grants++;
      end
      if (res_valido_a) begin
        if (ra < 3) chk($sformatf("rr_dig_a%0d", ra), 32'(res_digitos_a), 32'(hex_a[ra]));
        ra++;
      end
      if (res_valido_b) begin
        if (rb < 3) chk($sformatf("rr_dig_b%0d", rb), 32'(res_digitos_b), 32'(hex_b[rb]));
        rb++;
      end
      if (ra + rb >= 6) break;
      @(negedge clk);
    end
    chk("rr_res_a", 32'(ra), 32'd3);
    chk("rr_res_b", 32'(rb), 32'd3);
    chk("rr_grants", 32'(grants), 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/module_bcd_arbitro.md
MODULE_BCD_ARBITRO -- requirements
Module: module_BCD_arbitro

Interface
REQ-001 Parameter TIMEOUT_CICLOS, default 64, maximum cycles spent waiting for converter listo.
REQ-002 Parameter ANCHO, default 16, binary operand width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 sol_valido_a / sol_valido_b  input  1  requester A/B has an operand pending.
REQ-006 sol_numero_a / sol_numero_b  input  ANCHO  binary operand of A/B.
REQ-007 sol_acepta_a / sol_acepta_b  output  1  one-cycle grant; operand captured this cycle.
REQ-008 res_valido_a / res_valido_b  output  1  one-cycle result strobe to A/B.
REQ-009 res_digitos_a / res_digitos_b  output  16  {millares, centenas, decenas, unidades}, held between strobes.
REQ-010 bcd_numero  output  ANCHO  operand driven to the shared BCD converter.
REQ-011 bcd_unidades, bcd_decenas, bcd_centenas, bcd_millares  input  4 each  converter digits.
REQ-012 bcd_listo  input  1  converter done flag.
REQ-013 error_timeout  output  1  sticky flag, converter failed to finish.
REQ-014 fuera_rango  output  1  one-cycle pulse, operand above 9999 rejected.

Function
REQ-015 FSM states: REPOSO, LANZAR, ASENTAR, ESPERAR, ENTREGAR.
REQ-016 REPOSO: if any sol_valido, grant one requester, pulse its sol_acepta, latch its operand and identity, go LANZAR.
REQ-017 Arbitration round-robin: a simultaneous request goes to the requester not granted last; a lone request is granted immediately.
REQ-018 A requester holds sol_valido until sol_acepta; dropping sol_valido before the grant withdraws the request with no side effect.
REQ-019 At most one conversion is outstanding; no sol_acepta is asserted outside REPOSO.
REQ-020 Latched operand > 9999: skip the converter, go ENTREGAR with digits 16'hEEEE, pulse fuera_rango in ENTREGAR; bcd_numero unchanged.
REQ-021 LANZAR: drive bcd_numero with the latched operand; bcd_listo ignored. ASENTAR: bcd_listo ignored; then go ESPERAR.
REQ-022 ESPERAR: on the edge sampling bcd_listo=1, capture the four converter digits and go ENTREGAR.
REQ-023 ESPERAR timeout: wait counter clears on entry; at TIMEOUT_CICLOS-1 without listo, set error_timeout, load digits 16'hFFFF, go ENTREGAR.
REQ-024 ENTREGAR: pulse res_valido of the owning requester for exactly one cycle, update its res_digitos, return REPOSO.
REQ-025 The other requester's res_digitos and res_valido are never disturbed.
REQ-026 bcd_numero holds the last launched operand until the next LANZAR.
REQ-027 Latency, accept edge T to res_valido: minimum 4 cycles (listo already high); 1 cycle for out-of-range.
REQ-028 A new grant is possible in the REPOSO cycle right after ENTREGAR; back-to-back A,B requests alternate.

Reset
REQ-029 rst low asynchronously forces REPOSO, aborts any conversion, and suppresses any res_valido.
REQ-030 Reset values: all sol_acepta, res_valido and fuera_rango 0; res_digitos 0; bcd_numero 0; error_timeout 0; wait counter 0.
REQ-031 The last-granted pointer resets to B, so A wins the first simultaneous request.
REQ-032 error_timeout clears only on reset.

Structure
REQ-033 Package paquete_bcd_pkg holds the state enum, MAX_DECIMAL=9999, DIGITOS_RANGO=16'hEEEE and DIGITOS_TIMEOUT=16'hFFFF.
REQ-034 Round-robin grant logic lives in sub-module module_arbitro_rr (2 requests, 2 one-hot grants, advance input).

Verification
REQ-035 A alone with 1234, converter listo after 5 cycles -> sol_acepta_a once; res_valido_a once; res_digitos_a=16'h1234; B outputs unchanged.
REQ-036 A=5678 and B=910 raised together after reset -> A granted first, res_digitos_a=16'h5678; then B, res_digitos_b=16'h0910.
REQ-037 B=10000 -> sol_acepta_b; fuera_rango and res_valido_b in the next cycle; res_digitos_b=16'hEEEE; bcd_numero not changed.
REQ-038 bcd_listo stuck low, TIMEOUT_CICLOS=8, A=42 -> error_timeout set; res_digitos_a=16'hFFFF; error_timeout stays 1 until rst.
REQ-039 rst asserted in ESPERAR for A=1234 -> no res_valido_a; all outputs at reset values; the next request for 9999 gives 16'h9999.
REQ-040 A and B held valid continuously for 6 requests -> grants alternate A,B,A,B,A,B and each request gets exactly one result.
